ppu_sprite_scangen: RTL and testbench

//  Per-scanline sprite pixel generator, directly downstream of the PPU OAM controller. Captures up
//  to 8 sprite descriptors (y-offset, tile, attr, xpos), fetches each sprite's two pattern-plane

---
 rtl/ppu_sprite_scangen.sv | 188 ++++++++++++++++++
 tb/tb_ppu_sprite_scangen.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_sprite_scangen.sv
// Per-scanline sprite pixel generator: captures up to NUM_SLOTS sprite descriptors,
// fetches their pattern bytes and shifts out the winning sprite pixel each pixel clock.
module ppu_sprite_scangen #(
   parameter int         NUM_SLOTS = 8,
   parameter logic [7:0] EMPTY_X   = 8'd255
) (
   input  logic        clk_100mhz,
   input  logic        rst_n,
   input  logic        hsync,
   input  logic        pixel_en,
   input  logic        shift_enable,
   input  logic        load_sprite,
   input  logic [2:0]  sprite_yoffset,
   input  logic [7:0]  sprite_tile_num,
   input  logic [7:0]  sprite_attr,
   input  logic [7:0]  sprite_xpos,
   output logic        pat_rd,
   output logic [11:0] pat_addr,
   input  logic [7:0]  pat_dout,
   output logic [1:0]  spr_pix,
   output logic [1:0]  spr_pal,
   output logic        spr_pri,
   output logic        spr_zero,
   output logic        load_ovf
);

   typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, CAP_HI} fetch_state_t;

   fetch_state_t state;
   logic         hsync_q;
   logic         load_q;
   logic [2:0]   slot_idx;
   logic         slots_full;

   logic [7:0]   tile_q;
   logic [2:0]   row_q;
   logic [1:0]   pal_q;
   logic         pri_q;
   logic         hflip_q;
   logic [7:0]   xpos_q;
   logic [7:0]   lo_cap;

   logic [7:0]   slot_lo   [NUM_SLOTS];
   logic [7:0]   slot_hi   [NUM_SLOTS];
   logic [7:0]   slot_xcnt [NUM_SLOTS];
   logic [3:0]   slot_left [NUM_SLOTS];
   logic [1:0]   slot_pal  [NUM_SLOTS];
   logic         slot_pri  [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] slot_valid;

   logic         line_start;
   logic         load_edge;
   logic         load_accept;
   logic         advance;
   logic [2:0]   row_sel;
   logic         attr_unused;

   logic [1:0]   win_pix_p0;
   logic [1:0]   win_pal_p0;
   logic         win_pri_p0;
   logic         win_zero_p0;

   function automatic logic [7:0] bit_rev(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   assign line_start  = hsync & ~hsync_q;
   assign load_edge   = load_sprite & ~load_q;
   // A line start frees all slots, so a coincident load always finds room in slot 0.
   assign load_accept = load_edge & (state == IDLE) & (line_start | ~slots_full);
   assign advance     = pixel_en & shift_enable;
   assign row_sel     = sprite_attr[7] ? (3'd7 - sprite_yoffset) : sprite_yoffset;
   assign attr_unused = ^sprite_attr[4:2];

   always_ff @(posedge clk_100mhz) begin
      if (!rst_n) begin
         state      <= IDLE;
         pat_rd     <= 1'b0;
         pat_addr   <= '0;
         slot_idx   <= '0;
         slots_full <= 1'b0;
         slot_valid <= '0;
         load_ovf   <= 1'b0;
         hsync_q    <= 1'b0;
         load_q     <= 1'b0;
      end else begin
         hsync_q <= hsync;
         load_q  <= load_sprite;
         case (state)
            IDLE: begin
               if (load_accept) begin
                  state    <= RD_LO;
                  pat_rd   <= 1'b1;
                  pat_addr <= {sprite_tile_num, 1'b0, row_sel};
               end
            end
            RD_LO: begin
               state    <= RD_HI;
               pat_addr <= {tile_q, 1'b1, row_q};
            end
            RD_HI: begin
               state  <= CAP_HI;
               pat_rd <= 1'b0;
            end
            CAP_HI: begin
               state                <= IDLE;
               slot_valid[slot_idx] <= (xpos_q != EMPTY_X);
               slot_idx             <= slot_idx + 3'd1;
               if (slot_idx == 3'(NUM_SLOTS - 1)) slots_full <= 1'b1;
            end
            default: state <= IDLE;
         endcase
         if (load_edge && !load_accept) load_ovf <= 1'b1;
         if (line_start) begin
            slot_idx   <= '0;
            slots_full <= 1'b0;
            slot_valid <= '0;
            load_ovf   <= 1'b0;
         end
      end
   end

   // Descriptor latch, byte capture and per-slot shifters (data path, no reset).
   always_ff @(posedge clk_100mhz) begin
      if (load_accept) begin
         tile_q  <= sprite_tile_num;
         row_q   <= row_sel;
         pal_q   <= sprite_attr[1:0];
         pri_q   <= sprite_attr[5];
         hflip_q <= sprite_attr[6];
         xpos_q  <= sprite_xpos;
      end
      if (state == RD_HI) lo_cap <= hflip_q ? bit_rev(pat_dout) : pat_dout;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (advance) begin
            if (slot_xcnt[s] != 8'd0) begin
               slot_xcnt[s] <= slot_xcnt[s] - 8'd1;
            end else if (slot_left[s] != 4'd0) begin
               slot_lo[s]   <= {slot_lo[s][6:0], 1'b0};
               slot_hi[s]   <= {slot_hi[s][6:0], 1'b0};
               slot_left[s] <= slot_left[s] - 4'd1;
            end
         end
         if (state == CAP_HI && slot_idx == 3'(s)) begin
            slot_lo[s]   <= lo_cap;
            slot_hi[s]   <= hflip_q ? bit_rev(pat_dout) : pat_dout;
            slot_xcnt[s] <= xpos_q;
            slot_left[s] <= 4'd8;
            slot_pal[s]  <= pal_q;
            slot_pri[s]  <= pri_q;
         end
      end
   end

   always_comb begin
      win_pix_p0  = '0;
      win_pal_p0  = '0;
      win_pri_p0  = 1'b0;
      win_zero_p0 = 1'b0;
      for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
         if (slot_valid[s] && slot_xcnt[s] == 8'd0 && slot_left[s] != 4'd0 &&
             {slot_hi[s][7], slot_lo[s][7]} != 2'b00) begin
            win_pix_p0  = {slot_hi[s][7], slot_lo[s][7]};
            win_pal_p0  = slot_pal[s];
            win_pri_p0  = slot_pri[s];
            win_zero_p0 = (s == 0);
         end
      end
   end

   // Output stage: winner registered on each advance, blanked outside the active region.
   always_ff @(posedge clk_100mhz) begin
      if (!rst_n || !shift_enable) begin
         spr_pix  <= '0;
         spr_pal  <= '0;
         spr_pri  <= 1'b0;
         spr_zero <= 1'b0;
      end else if (pixel_en) begin
         spr_pix  <= win_pix_p0;
         spr_pal  <= win_pal_p0;
         spr_pri  <= win_pri_p0;
         spr_zero <= win_zero_p0;
      end
   end

endmodule

// File: tb/tb_ppu_sprite_scangen.sv
// Directed bench for ppu_sprite_scangen with a one-cycle-latency pattern memory model.
module tb_ppu_sprite_scangen;

   logic        clk_100mhz = 1'b0;
   logic        rst_n;
   logic        hsync;
   logic        pixel_en;
   logic        shift_enable;
   logic        load_sprite;
   logic [2:0]  sprite_yoffset;
   logic [7:0]  sprite_tile_num;
   logic [7:0]  sprite_attr;
   logic [7:0]  sprite_xpos;
   logic        pat_rd;
   logic [11:0] pat_addr;
   logic [7:0]  pat_dout;
   logic [1:0]  spr_pix;
   logic [1:0]  spr_pal;
   logic        spr_pri;
   logic        spr_zero;
   logic        load_ovf;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  pat_mem [0:4095];
   logic [11:0] rd_addr [0:255];
   int          rd_cnt = 0;

   always #5 clk_100mhz = ~clk_100mhz;

   ppu_sprite_scangen dut (
      .clk_100mhz      (clk_100mhz),
      .rst_n           (rst_n),
      .hsync           (hsync),
      .pixel_en        (pixel_en),
      .shift_enable    (shift_enable),
      .load_sprite     (load_sprite),
      .sprite_yoffset  (sprite_yoffset),
      .sprite_tile_num (sprite_tile_num),
      .sprite_attr     (sprite_attr),
      .sprite_xpos     (sprite_xpos),
      .pat_rd          (pat_rd),
      .pat_addr        (pat_addr),
      .pat_dout        (pat_dout),
      .spr_pix         (spr_pix),
      .spr_pal         (spr_pal),
      .spr_pri         (spr_pri),
      .spr_zero        (spr_zero),
      .load_ovf        (load_ovf)
   );

   // Pattern memory: data one cycle after the read strobe; every read address is logged.
   always @(posedge clk_100mhz) begin
      if (pat_rd) begin
         pat_dout                <= pat_mem[pat_addr];
         rd_addr[rd_cnt & 255]   <= pat_addr;
         rd_cnt                  <= rd_cnt + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_100mhz);
         #1;
      end
   endtask

   task automatic new_line();
      shift_enable = 1'b0;
      hsync        = 1'b1;
      tick(1);
      hsync        = 1'b0;
      tick(1);
   endtask

   task automatic load_desc(input logic [2:0] y, input logic [7:0] tile, input logic [7:0] attr,
                            input logic [7:0] x);
      sprite_yoffset  = y;
      sprite_tile_num = tile;
      sprite_attr     = attr;
      sprite_xpos     = x;
      load_sprite     = 1'b1;
      tick(2);
      load_sprite     = 1'b0;
      tick(3);
   endtask

   task automatic step_pixel();
      tick(3);
      pixel_en = 1'b1;
      tick(1);
      pixel_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      n_cmp++;
      if ({pat_rd, spr_pix, spr_pal, spr_pri, spr_zero, load_ovf} !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b expected 00000000",
                  {pat_rd, spr_pix, spr_pal, spr_pri, spr_zero, load_ovf});
      end
      n_cmp++;
      if (pat_addr !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_pat_addr: got %h expected 000", pat_addr);
      end
      shift_enable = 1'b1;
      step_pixel();
      n_cmp++;
      if (spr_pix !== 2'd0) begin
         n_bad++;
         $display("FAIL reset_no_slots: got pix %0d expected 0", spr_pix);
      end
      shift_enable = 1'b0;
      tick(1);
   endtask

   task automatic test_basic();
      int base;
      pat_mem[12'h123] = 8'hF0;
      pat_mem[12'h12B] = 8'h0F;
      new_line();
      base = rd_cnt;
      load_desc(3'd3, 8'h12, 8'h00, 8'd0);
      n_cmp++;
      if (rd_cnt - base !== 2) begin
         n_bad++;
         $display("FAIL basic_read_count: got %0d expected 2", rd_cnt - base);
      end
      n_cmp++;
      if (rd_addr[base] !== 12'h123 || rd_addr[base+1] !== 12'h12B) begin
         n_bad++;
         $display("FAIL basic_pat_addr: got %h/%h expected 123/12B", rd_addr[base], rd_addr[base+1]);
      end
      shift_enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step_pixel();
         n_cmp++;
         if (spr_pix !== 2'd1) begin
            n_bad++;
            $display("FAIL basic_pix%0d: got %0d expected 1", i, spr_pix);
         end
      end
      n_cmp++;
      if ({spr_zero, spr_pal, spr_pri} !== 4'b1000) begin
         n_bad++;
         $display("FAIL basic_zero_pal_pri: got %b expected 1000", {spr_zero, spr_pal, spr_pri});
      end
      shift_enable = 1'b0;
      tick(1);
      n_cmp++;
      if (spr_pix !== 2'd0) begin
         n_bad++;
         $display("FAIL gate_off_blank: got %0d expected 0", spr_pix);
      end
      pixel_en = 1'b1;
      tick(1);
      pixel_en = 1'b0;
      tick(2);
      shift_enable = 1'b1;
      for (int i = 4; i < 8; i++) begin
         step_pixel();
         n_cmp++;
         if (spr_pix !== 2'd2) begin
            n_bad++;
            $display("FAIL basic_pix%0d: got %0d expected 2", i, spr_pix);
         end
      end
      step_pixel();
      n_cmp++;
      if (spr_pix !== 2'd0) begin
         n_bad++;
         $display("FAIL basic_after_end: got %0d expected 0", spr_pix);
      end
      n_cmp++;
      if (load_ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_no_ovf: got %b expected 0", load_ovf);
      end
   endtask

   task automatic test_flip();
      int base;
      logic [1:0] exp_pix;
      pat_mem[12'h200] = 8'h80;
      pat_mem[12'h208] = 8'h00;
      new_line();
      load_desc(3'd0, 8'h20, 8'h61, 8'd0);
      shift_enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step_pixel();
         exp_pix = (i == 7) ? 2'd1 : 2'd0;
         n_cmp++;
         if (spr_pix !== exp_pix) begin
            n_bad++;
            $display("FAIL hflip_pix%0d: got %0d expected %0d", i, spr_pix, exp_pix);
         end
      end
      n_cmp++;
      if ({spr_pal, spr_pri, spr_zero} !== 4'b0111) begin
         n_bad++;
         $display("FAIL hflip_pal_pri: got %b expected 0111", {spr_pal, spr_pri, spr_zero});
      end
      pat_mem[12'h215] = 8'hC0;
      pat_mem[12'h21D] = 8'h40;
      new_line();
      base = rd_cnt;
      load_desc(3'd2, 8'h21, 8'h83, 8'd0);
      n_cmp++;
      if (rd_addr[base] !== 12'h215 || rd_addr[base+1] !== 12'h21D) begin
         n_bad++;
         $display("FAIL vflip_pat_addr: got %h/%h expected 215/21D", rd_addr[base], rd_addr[base+1]);
      end
      shift_enable = 1'b1;
      step_pixel();
      n_cmp++;
      if ({spr_pix, spr_pal} !== 4'b0111) begin
         n_bad++;
         $display("FAIL vflip_pix0: got pix/pal %b expected 0111", {spr_pix, spr_pal});
      end
      step_pixel();
      n_cmp++;
      if (spr_pix !== 2'd3) begin
         n_bad++;
         $display("FAIL vflip_pix1: got %0d expected 3", spr_pix);
      end
      step_pixel();
      n_cmp++;
      if (spr_pix !== 2'd0) begin
         n_bad++;
         $display("FAIL vflip_pix2: got %0d expected 0", spr_pix);
      end
   endtask

   task automatic test_priority();
      pat_mem[12'h300] = 8'hFF;
      pat_mem[12'h308] = 8'hFF;
      pat_mem[12'h310] = 8'hFF;
      pat_mem[12'h318] = 8'h00;
      pat_mem[12'h320] = 8'h00;
      pat_mem[12'h328] = 8'h00;
      new_line();
      load_desc(3'd0, 8'h30, 8'h02, 8'd10);
      load_desc(3'd0, 8'h31, 8'h01, 8'd10);
      shift_enable = 1'b1;
      repeat (10) step_pixel();
      n_cmp++;
      if (spr_pix !== 2'd0) begin
         n_bad++;
         $display("FAIL prio_before_col: got %0d expected 0", spr_pix);
      end
      step_pixel();
      n_cmp++;
      if ({spr_pix, spr_pal, spr_zero} !== 5'b11101) begin
         n_bad++;
         $display("FAIL prio_slot0_wins: got %b expected 11101", {spr_pix, spr_pal, spr_zero});
      end
      repeat (7) step_pixel();
      n_cmp++;
      if (spr_pix !== 2'd3) begin
         n_bad++;
         $display("FAIL prio_last_col: got %0d expected 3", spr_pix);
      end
      step_pixel();
      n_cmp++;
      if (spr_pix !== 2'd0) begin
         n_bad++;
         $display("FAIL prio_past_end: got %0d expected 0", spr_pix);
      end
      new_line();
      load_desc(3'd0, 8'h32, 8'h02, 8'd10);
      load_desc(3'd0, 8'h31, 8'h01, 8'd10);
      shift_enable = 1'b1;
      repeat (11) step_pixel();
      n_cmp++;
      if ({spr_pix, spr_pal, spr_zero} !== 5'b01010) begin
         n_bad++;
         $display("FAIL prio_transparent: got %b expected 01010", {spr_pix, spr_pal, spr_zero});
      end
   endtask

   task automatic test_empty_ovf();
      int base;
      int nz;
      new_line();
      base = rd_cnt;
      for (int i = 0; i < 8; i++) load_desc(3'd0, 8'h30, 8'h00, 8'd255);
      n_cmp++;
      if (load_ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL eight_loads_ovf: got %b expected 0", load_ovf);
      end
      load_desc(3'd0, 8'h30, 8'h00, 8'd0);
      n_cmp++;
      if (load_ovf !== 1'b1) begin
         n_bad++;
         $display("FAIL ninth_load_ovf: got %b expected 1", load_ovf);
      end
      n_cmp++;
      if (rd_cnt - base !== 16) begin
         n_bad++;
         $display("FAIL ninth_load_reads: got %0d expected 16", rd_cnt - base);
      end
      shift_enable = 1'b1;
      nz = 0;
      for (int i = 0; i < 256; i++) begin
         step_pixel();
         if (spr_pix !== 2'd0) nz++;
      end
      n_cmp++;
      if (nz !== 0) begin
         n_bad++;
         $display("FAIL empty_line_pixels: got %0d visible expected 0", nz);
      end
   endtask

   task automatic test_back_to_back();
      new_line();
      sprite_yoffset  = 3'd0;
      sprite_tile_num = 8'h30;
      sprite_attr     = 8'h00;
      sprite_xpos     = 8'd20;
      load_sprite     = 1'b1;
      tick(1);
      load_sprite     = 1'b0;
      tick(1);
      sprite_tile_num = 8'h31;
      sprite_attr     = 8'h01;
      sprite_xpos     = 8'd0;
      load_sprite     = 1'b1;
      tick(2);
      load_sprite     = 1'b0;
      tick(3);
      n_cmp++;
      if (load_ovf !== 1'b1) begin
         n_bad++;
         $display("FAIL busy_drop_ovf: got %b expected 1", load_ovf);
      end
      shift_enable = 1'b1;
      step_pixel();
      n_cmp++;
      if (spr_pix !== 2'd0) begin
         n_bad++;
         $display("FAIL busy_dropped_pix: got %0d expected 0", spr_pix);
      end
      repeat (20) step_pixel();
      n_cmp++;
      if ({spr_pix, spr_zero} !== 3'b111) begin
         n_bad++;
         $display("FAIL busy_first_kept: got %b expected 111", {spr_pix, spr_zero});
      end
      new_line();
      n_cmp++;
      if (load_ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL hsync_clears_ovf: got %b expected 0", load_ovf);
      end
   endtask

   task automatic test_reset_midfetch();
      int base;
      new_line();
      sprite_yoffset  = 3'd0;
      sprite_tile_num = 8'h30;
      sprite_attr     = 8'h00;
      sprite_xpos     = 8'd0;
      load_sprite     = 1'b1;
      tick(1);
      load_sprite     = 1'b0;
      tick(1);
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
      n_cmp++;
      if ({pat_rd, spr_pix, spr_pal, spr_pri, spr_zero, load_ovf} !== 8'h00) begin
         n_bad++;
         $display("FAIL midfetch_outputs: got %b expected 00000000",
                  {pat_rd, spr_pix, spr_pal, spr_pri, spr_zero, load_ovf});
      end
      shift_enable = 1'b1;
      step_pixel();
      n_cmp++;
      if (spr_pix !== 2'd0) begin
         n_bad++;
         $display("FAIL midfetch_no_slot: got %0d expected 0", spr_pix);
      end
      shift_enable = 1'b0;
      tick(1);
      base = rd_cnt;
      load_desc(3'd0, 8'h31, 8'h01, 8'd0);
      n_cmp++;
      if (rd_cnt - base !== 2 || rd_addr[base] !== 12'h310 || load_ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL midfetch_reload: got reads %0d addr %h ovf %b expected 2 310 0",
                  rd_cnt - base, rd_addr[base], load_ovf);
      end
      shift_enable = 1'b1;
      step_pixel();
      n_cmp++;
      if ({spr_pix, spr_zero} !== 3'b011) begin
         n_bad++;
         $display("FAIL midfetch_slot0: got %b expected 011", {spr_pix, spr_zero});
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached with %0d compared", n_cmp);
      $fatal(1);
   end

   initial begin
      rst_n           = 1'b0;
      hsync           = 1'b0;
      pixel_en        = 1'b0;
      shift_enable    = 1'b0;
      load_sprite     = 1'b0;
      sprite_yoffset  = 3'd0;
      sprite_tile_num = 8'h00;
      sprite_attr     = 8'h00;
      sprite_xpos     = 8'h00;
      for (int a = 0; a < 4096; a++) pat_mem[a] = 8'h00;
      test_reset();
      test_basic();
      test_flip();
      test_priority();
      test_empty_ovf();
      test_back_to_back();
      test_reset_midfetch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
